// File: rtl/memory_map_pkg.sv
// Shared constants for the SysBus memory map: region bounds, I/O register
// offsets, status bit positions and the bus-cycle state type.
package memmap;

   localparam logic [15:0] ROM_LIMIT = 16'h7FFF;
   localparam logic [15:0] RAM_BASE  = 16'h8000;
   localparam logic [15:0] RAM_LIMIT = 16'hFEFF;
   localparam logic [15:0] IO_BASE   = 16'hFF00;

   localparam logic [7:0] OFF_LED  = 8'h00;
   localparam logic [7:0] OFF_SW   = 8'h01;
   localparam logic [7:0] OFF_TCNT = 8'h02;
   localparam logic [7:0] OFF_TCMP = 8'h03;
   localparam logic [7:0] OFF_CTRL = 8'h04;
   localparam logic [7:0] OFF_STAT = 8'h05;

   localparam int STAT_MATCH  = 0;
   localparam int STAT_BUSERR = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACTIVE = 2'd2
   } bus_state_t;

endpackage

// File: rtl/memory_map_io_timer.sv
// Free-running 16-bit timer with compare register, enable bit and a sticky
// match flag; written through the I/O register write port.
module io_timer
   import memmap::*;
#(
   parameter logic [15:0] TIMER_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [7:0]  wr_offset,
   input  logic [15:0] wr_data,
   output logic [15:0] tcnt,
   output logic [15:0] tcmp,
   output logic        enable,
   output logic        match
);

   logic [15:0] tcnt_next;
   logic [15:0] tcmp_next;
   logic        enable_next;
   logic        match_next;

   // A register write overrides the increment; a match overrides a W1C clear.
   always_comb begin
      tcnt_next   = enable ? tcnt + 16'd1 : tcnt;
      tcmp_next   = tcmp;
      enable_next = enable;
      match_next  = match;
      if (wr_en) begin
         case (wr_offset)
            OFF_TCNT: tcnt_next   = wr_data;
            OFF_TCMP: tcmp_next   = wr_data;
            OFF_CTRL: enable_next = wr_data[0];
            OFF_STAT: if (wr_data[STAT_MATCH]) match_next = 1'b0;
            default:  ;
         endcase
      end
      if (tcnt_next == tcmp_next) match_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt   <= TIMER_RESET;
         tcmp   <= 16'hFFFF;
         enable <= 1'b0;
         match  <= 1'b0;
      end else begin
         tcnt   <= tcnt_next;
         tcmp   <= tcmp_next;
         enable <= enable_next;
         match  <= match_next;
      end
   end

endmodule

// File: rtl/memory_map.sv
// SysBus memory-map controller: latches the address phase, decodes ROM/RAM/I/O,
// drives chip selects and hosts the LED/switch/timer/status register block.
module memory_map
   import memmap::*;
#(
   parameter logic [15:0] TIMER_RESET = 16'h0000,
   parameter int          SW_WIDTH    = 8
) (
   input  logic                Clock,
   input  logic                nReset,
   input  logic [15:0]         SysBusIn,
   output logic [15:0]         SysBusOut,
   output logic                SysBusOe,
   input  logic                ALE,
   input  logic                nME,
   input  logic                nOE,
   input  logic                nWE,
   output logic [15:0]         MemAddr,
   output logic                nRomCs,
   output logic                nRamCs,
   input  logic [SW_WIDTH-1:0] Switches,
   output logic [15:0]         Leds,
   output logic                Irq
);

   bus_state_t          state;
   bus_state_t          state_next;
   logic                wr_done;
   logic                wr_done_next;
   logic                bus_err_set;
   logic                commit;
   logic [15:0]         led;
   logic                bus_err;
   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_sync;
   logic [15:0]         sw_ext;
   logic                is_rom;
   logic                is_ram;
   logic                is_io;
   logic                sel_active;
   logic [7:0]          offset;
   logic [15:0]         rd_data;
   logic [15:0]         tcnt;
   logic [15:0]         tcmp;
   logic                timer_en;
   logic                match;

   assign offset = MemAddr[7:0];
   assign is_rom = (MemAddr <= ROM_LIMIT);
   assign is_ram = (MemAddr >= RAM_BASE) && (MemAddr <= RAM_LIMIT);
   assign is_io  = (MemAddr >= IO_BASE);

   // ALE takes precedence over nME so a fresh address phase always restarts the cycle.
   always_comb begin
      state_next  = state;
      bus_err_set = 1'b0;
      case (state)
         IDLE: begin
            if (ALE) state_next = ADDR;
            if (!nME) bus_err_set = 1'b1;
         end
         ADDR: begin
            if (ALE)       state_next = ADDR;
            else if (!nME) state_next = ACTIVE;
         end
         ACTIVE: begin
            if (ALE)      state_next = ADDR;
            else if (nME) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign commit = (state == ACTIVE) && !nWE && !wr_done && is_io;

   always_comb begin
      wr_done_next = wr_done;
      if (state_next != ACTIVE)
         wr_done_next = 1'b0;
      else if ((state == ACTIVE) && !nWE)
         wr_done_next = 1'b1;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         wr_done <= 1'b0;
         MemAddr <= 16'h0000;
      end else begin
         state   <= state_next;
         wr_done <= wr_done_next;
         if (ALE) MemAddr <= SysBusIn;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         led     <= 16'h0000;
         bus_err <= 1'b0;
      end else begin
         if (commit && (offset == OFF_LED)) led <= SysBusIn;
         if (bus_err_set)
            bus_err <= 1'b1;
         else if (commit && (offset == OFF_STAT) && SysBusIn[STAT_BUSERR])
            bus_err <= 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= Switches;
         sw_sync <= sw_meta;
      end
   end

   io_timer #(
      .TIMER_RESET(TIMER_RESET)
   ) u_timer (
      .clk      (Clock),
      .rst_n    (nReset),
      .wr_en    (commit),
      .wr_offset(offset),
      .wr_data  (SysBusIn),
      .tcnt     (tcnt),
      .tcmp     (tcmp),
      .enable   (timer_en),
      .match    (match)
   );

   always_comb begin
      sw_ext = '0;
      sw_ext[SW_WIDTH-1:0] = sw_sync;
   end

   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_LED:  rd_data = led;
         OFF_SW:   rd_data = sw_ext;
         OFF_TCNT: rd_data = tcnt;
         OFF_TCMP: rd_data = tcmp;
         OFF_CTRL: rd_data[0] = timer_en;
         OFF_STAT: begin
            rd_data[STAT_MATCH]  = match;
            rd_data[STAT_BUSERR] = bus_err;
         end
         default:  ;
      endcase
   end

   assign sel_active = (state != IDLE) && !nME;
   assign nRomCs     = !(sel_active && is_rom);
   assign nRamCs     = !(sel_active && is_ram);
   assign SysBusOe   = is_io && (state == ACTIVE) && !nOE && nWE;
   assign SysBusOut  = SysBusOe ? rd_data : 16'h0000;
   assign Leds       = led;
   assign Irq        = match;

endmodule

// File: doc/memory_map.md
# memory_map

Memory-map controller on the CPU side of the multiplexed 16-bit SysBus, directly downstream of the `control` sequencer whose ALE/nME/nOE/nWE strobes it consumes. It latches the address phase, decodes ROM, RAM and on-chip I/O regions, and drives external chip selects and the latched address. It also hosts the I/O register block (LEDs, switches, timer, status) and returns I/O read data onto SysBus.

## Interface
Parameters:
- `TIMER_RESET` — 16'h0000 — timer count value after reset.
- `SW_WIDTH` — 8 — number of switch inputs.

Ports:
- `Clock` — in — 1 — system clock. One clock domain; all state updates on the rising edge.
- `nReset` — in — 1 — reset, asynchronous, active-low.
- `SysBusIn` — in — 16 — SysBus value: address during ALE, write data during writes.
- `SysBusOut` — out — 16 — I/O read data.
- `SysBusOe` — out — 1 — drive enable for `SysBusOut`.
- `ALE` — in — 1 — address latch enable, active-high.
- `nME` — in — 1 — memory cycle enable, active-low.
- `nOE` — in — 1 — output enable, active-low (read).
- `nWE` — in — 1 — write enable, active-low.
- `MemAddr` — out — 16 — latched address to external memories.
- `nRomCs` — out — 1 — ROM chip select, active-low.
- `nRamCs` — out — 1 — RAM chip select, active-low.
- `Switches` — in — `SW_WIDTH` — asynchronous switch inputs.
- `Leds` — out — 16 — LED register contents.
- `Irq` — out — 1 — timer match flag, level.

## Operation
Address map, decoded from `MemAddr`:
- 0000–7FFF: ROM.
- 8000–FEFF: RAM.
- FF00–FFFF: I/O.

I/O registers (offset = `MemAddr[7:0]`):
- 00 `LED` — read/write.
- 01 `SW` — read-only; zero-extended, synchronised value.
- 02 `TCNT` — read/write.
- 03 `TCMP` — read/write.
- 04 `CTRL` — read/write; bit0 = timer enable.
- 05 `STAT` — bit0 = timer match, bit1 = bus error; write-1-to-clear.
- Other offsets read 0 and ignore writes.

Bus-cycle FSM:
- `IDLE`: on ALE=1, latch `SysBusIn` into `MemAddr` and go to `ADDR`. If nME=0 is sampled in `IDLE`, set `STAT[1]`; no selects are asserted.
- `ADDR`: on nME=0, go to `ACTIVE`. On ALE=1, re-latch the address and stay in `ADDR`.
- `ACTIVE`: on nME=1, go to `IDLE`. If ALE=1 is sampled here, latch the address and go to `ADDR` (this ends the cycle).

Chip selects and read drive:
- `nRomCs`/`nRamCs` are low combinationally when nME=0 and the FSM is in `ADDR` or `ACTIVE` with the matching region; otherwise high.
- I/O region: `SysBusOe` = `ACTIVE` & !nOE & nWE; `SysBusOut` is the selected register. Outside that condition `SysBusOut` = 0.

I/O writes:
- A write commits on the first rising edge in `ACTIVE` with nWE=0, using `SysBusIn` at that edge.
- A `wrDone` flag blocks repeat commits until the FSM leaves `ACTIVE`.
- Writes to ROM/RAM regions only affect the chip selects.

Timer:
- When `CTRL[0]`=1, `TCNT` increments every clock and wraps FFFF→0000.
- When `TCNT` equals `TCMP` (compared after update), `STAT[0]` sets. `Irq` = `STAT[0]`.
- A `TCNT` write on the same edge as an increment: the write wins.
- A match on the same edge as a W1C clear of `STAT[0]`: set wins.

Switches: two-flop synchroniser per bit.

## Timing
- Reset values:
  - FSM `IDLE`, `MemAddr`=0, `wrDone`=0.
  - `LED`=0, `TCNT`=`TIMER_RESET`, `TCMP`=FFFF, `CTRL`=0, `STAT`=0.
  - Synchroniser flops 0.
  - Outputs: `SysBusOe`=0, `SysBusOut`=0, `nRomCs`=`nRamCs`=1, `Leds`=0, `Irq`=0.
- Address latch: `MemAddr` is valid one cycle after the edge that sampled ALE=1.
- Read: I/O data is visible combinationally in the same cycle as nOE=0 in `ACTIVE`. The CPU samples it on the following edge.
- Write: the register updates at the committing edge and is visible on reads one cycle later.
- Switch latency: 2 cycles from the input to the `SW` read value.
- Reset asserted mid-cycle: everything returns to its reset value immediately; the pending write is discarded.

## Structure
- Package `memmap`: region base/limit constants, I/O offset constants, FSM state enum `bus_state_t`, `STAT` bit indices.
- One sub-module, `io_timer`: holds `TCNT`, `TCMP`, enable, match set/clear priority, and the write port. All other logic stays in `memory_map`.

## Test plan
- Fetch-style read: ALE with bus 0x0010, then nME=0, nOE=0 → `MemAddr`=0x0010, `nRomCs`=0, `nRamCs`=1, `SysBusOe`=0.
- STW to LED: ALE 0xFF00, then nME=0, then nWE=0 for 2 cycles with data 0xA5C3 → `Leds`=0xA5C3 after exactly one commit. A changed bus value in the second nWE cycle is ignored.
- Timer: write `TCMP`=5, `TCNT`=0, `CTRL`=1 → `Irq` rises 5 cycles after enable. Write `STAT`=1 → `Irq`=0. After wrap, `Irq` sets again.
- Switch read: `Switches`=0x3C → reading 0xFF01 returns 0x003C with `SysBusOe`=1 during the nOE=0 cycles only.
- Bus error: nME=0 with no prior ALE → `STAT[1]`=1, both chip selects stay high. Writing `STAT`=2 clears it.
- Reset mid-write: nReset low during `ACTIVE` with nWE=0 → `Leds`=0, FSM `IDLE`, all selects high.
